// File: rtl/function_f_mac_engine_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : function_f_pkg
// Brief  : Shared types and the saturation helper for function_f_mac_engine.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package function_f_pkg;

  // Widest intermediate the saturation helper accepts; ACC_WIDTH must not exceed it.
  localparam int SAT_W = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    FINAL = 3'd3,
    OUT   = 3'd4
  } ff_state_t;

  typedef enum logic [1:0] {
    SEL_ID     = 2'd0,
    SEL_BASIS  = 2'd1,
    SEL_OFFSET = 2'd2,
    SEL_RSVD   = 2'd3
  } ff_wsel_t;

  // Returns {over, under}: whether t lies above/below the signed dw-bit range.
  function automatic logic [1:0] sat_dir(input logic signed [SAT_W-1:0] t,
                                         input int unsigned dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
    lo = -hi - $signed(SAT_W'(1));
    return {(t > hi), (t < lo)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/function_f_mac_engine_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : function_f_mac_engine_if
// Brief  : Write port, start/busy and result handshake of the MAC engine.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface function_f_mac_engine_if #(
  parameter int NUM_ELEMENTS = 50,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_PARALLEL = 3
);
  localparam int ADDR_WIDTH = $clog2(NUM_ELEMENTS);
  localparam int CH_WIDTH   = (NUM_PARALLEL > 1) ? $clog2(NUM_PARALLEL) : 1;

  logic                               wr_en;
  logic [1:0]                         wr_sel;
  logic [CH_WIDTH-1:0]                wr_ch;
  logic [ADDR_WIDTH-1:0]              wr_addr;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               wr_err;
  logic                               start;
  logic                               busy;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_PARALLEL*DATA_WIDTH-1:0] result;
  logic [NUM_PARALLEL-1:0]            sat_flag;

  // Host / consumer side
  modport master (
    output wr_en, wr_sel, wr_ch, wr_addr, wr_data, start, out_ready,
    input  wr_err, busy, out_valid, result, sat_flag
  );

  // Engine side
  modport slave (
    input  wr_en, wr_sel, wr_ch, wr_addr, wr_data, start, out_ready,
    output wr_err, busy, out_valid, result, sat_flag
  );

endinterface
`default_nettype wire

// File: rtl/function_f_mac_engine_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : function_f_mac_lane
// Brief  : One output channel: basis RAM, offset, product and accumulate
//          stages, and the final shift/offset/saturate step.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module function_f_mac_lane
  import function_f_pkg::*;
#(
  parameter int NUM_ELEMENTS = 50,
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 64,
  parameter int FRAC_BITS    = 16,
  parameter int ADDR_WIDTH   = 6
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  basis_we_i,
  input  wire logic                  off_we_i,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  wire logic [DATA_WIDTH-1:0] wr_data_i,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  wire logic [DATA_WIDTH-1:0] id_i,
  input  wire logic                  mul_en_i,
  input  wire logic                  acc_clr_i,
  input  wire logic                  final_en_i,
  output logic      [DATA_WIDTH-1:0] result_o,
  output logic                       sat_o
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic        [DATA_WIDTH-1:0] basis_mem_q [NUM_ELEMENTS];
  logic signed [DATA_WIDTH-1:0] off_q;
  logic signed [PROD_W-1:0]     prod_q;
  logic                         prod_vld_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic        [DATA_WIDTH-1:0] result_q;
  logic                         sat_q;

  logic signed [PROD_W-1:0]     w_id_x;
  logic signed [PROD_W-1:0]     w_basis_x;
  logic signed [ACC_WIDTH-1:0]  w_prod_x;
  logic signed [ACC_WIDTH-1:0]  w_t;
  logic        [1:0]            w_dir;

  // Operands sign-extended to the product width so the multiply is exact.
  assign w_id_x    = PROD_W'($signed(id_i));
  assign w_basis_x = PROD_W'($signed(basis_mem_q[rd_addr_i]));
  assign w_prod_x  = ACC_WIDTH'(prod_q);
  assign w_t       = (acc_q >>> FRAC_BITS) + ACC_WIDTH'(off_q);
  assign w_dir     = sat_dir(SAT_W'(w_t), DATA_WIDTH);

  // Basis storage: written from the host port, never reset.
  always_ff @(posedge clk) begin
    if (basis_we_i) basis_mem_q[wr_addr_i] <= wr_data_i;
  end

  // Per-channel offset register, also left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (off_we_i) off_q <= $signed(wr_data_i);
  end

  // Stage 1: register the product of the current element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= mul_en_i;
      if (mul_en_i) prod_q <= w_id_x * w_basis_x;
    end
  end

  // Stage 2: accumulate; cleared when a new evaluation starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (acc_clr_i) begin
      acc_q <= '0;
    end else if (prod_vld_q) begin
      acc_q <= acc_q + w_prod_x;
    end
  end

  // Final stage: clamp the shifted, offset sum into the data word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      sat_q    <= 1'b0;
    end else if (final_en_i) begin
      sat_q <= |w_dir;
      if (w_dir[1])      result_q <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (w_dir[0]) result_q <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else               result_q <= w_t[DATA_WIDTH-1:0];
    end
  end

  assign result_o = result_q;
  assign sat_o    = sat_q;

endmodule
`default_nettype wire

// File: rtl/function_f_mac_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : function_f_mac_engine
// Brief  : Buffers id vector, basis matrix and offsets, then evaluates all
//          channels in parallel and returns results over valid/ready.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module function_f_mac_engine
  import function_f_pkg::*;
#(
  parameter int NUM_ELEMENTS = 50,
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 64,
  parameter int FRAC_BITS    = 16,
  parameter int NUM_PARALLEL = 3
) (
  input wire logic          clk,
  input wire logic          rst,
  function_f_mac_engine_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(NUM_ELEMENTS);
  localparam int CH_WIDTH   = (NUM_PARALLEL > 1) ? $clog2(NUM_PARALLEL) : 1;
  localparam logic [ADDR_WIDTH-1:0] C_K_LAST = ADDR_WIDTH'(NUM_ELEMENTS - 1);

  ff_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic                  wr_err_q;
  logic [DATA_WIDTH-1:0] id_mem_q [NUM_ELEMENTS];

  ff_wsel_t              w_sel;
  logic                  w_bad;
  logic                  w_accept;
  logic                  w_start_acc;
  logic                  w_id_we;

  // Write legality: reserved select, element index out of range, channel out of range.
  assign w_sel       = ff_wsel_t'(bus.wr_sel);
  assign w_bad       = (w_sel == SEL_RSVD)
                     || (((w_sel == SEL_ID) || (w_sel == SEL_BASIS))
                         && (int'(bus.wr_addr) >= NUM_ELEMENTS))
                     || (((w_sel == SEL_BASIS) || (w_sel == SEL_OFFSET))
                         && (int'(bus.wr_ch) >= NUM_PARALLEL));
  assign w_accept    = bus.wr_en && (state_q == IDLE) && !w_bad;
  assign w_start_acc = bus.start && (state_q == IDLE);
  assign w_id_we     = w_accept && (w_sel == SEL_ID);

  // Id vector storage shared by every lane.
  always_ff @(posedge clk) begin
    if (w_id_we) id_mem_q[bus.wr_addr] <= bus.wr_data;
  end

  // Rejected writes report one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_err_q <= 1'b0;
    else      wr_err_q <= bus.wr_en && !w_accept;
  end

  // State and element-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: one element per RUN cycle, then two pipeline-drain steps.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        k_d = k_q + ADDR_WIDTH'(1);
        if (k_q == C_K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
        end
      end
      DRAIN:   state_d = FINAL;
      FINAL:   state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_err    = wr_err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == OUT);

  for (genvar c = 0; c < NUM_PARALLEL; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_sat;
    logic                  w_ch_hit;

    assign w_ch_hit = w_accept && (bus.wr_ch == CH_WIDTH'(c));

    function_f_mac_lane #(
      .NUM_ELEMENTS (NUM_ELEMENTS),
      .DATA_WIDTH   (DATA_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH),
      .FRAC_BITS    (FRAC_BITS),
      .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .basis_we_i (w_ch_hit && (w_sel == SEL_BASIS)),
      .off_we_i   (w_ch_hit && (w_sel == SEL_OFFSET)),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .rd_addr_i  (k_q),
      .id_i       (id_mem_q[k_q]),
      .mul_en_i   (state_q == RUN),
      .acc_clr_i  (w_start_acc),
      .final_en_i (state_q == FINAL),
      .result_o   (w_res),
      .sat_o      (w_sat)
    );

    assign bus.result[c*DATA_WIDTH +: DATA_WIDTH] = w_res;
    assign bus.sat_flag[c]                        = w_sat;
  end

endmodule
`default_nettype wire
